// File: rtl/roi_readout_sequencer_pkg.sv
// Shared qubit readout package: default geometry of the ROI store, the sweep FSM
// state encoding and small arithmetic helpers used by the readout sequencer.
package roi_readout_sequencer_pkg;

    localparam int ROI_BITS        = 72;
    localparam int NUM_QUBITS      = 100;
    localparam int NUM_LANES       = 4;
    localparam int BANK_ADDR_WIDTH = 5;
    localparam int QUBIT_ID_WIDTH  = 7;
    localparam int MAX_LANES       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

    // Saturating increment for the 8-bit overrun counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/roi_readout_sequencer_if.sv
// ROI output beat stream: valid/ready handshake carrying one qubit word per beat.
interface roi_readout_sequencer_if #(
    parameter int ROI_BITS       = roi_readout_sequencer_pkg::ROI_BITS,
    parameter int QUBIT_ID_WIDTH = roi_readout_sequencer_pkg::QUBIT_ID_WIDTH
) ();

    logic                      o_roi_valid;
    logic                      i_roi_ready;
    logic [ROI_BITS-1:0]       o_roi_data;
    logic [QUBIT_ID_WIDTH-1:0] o_qubit_id;
    logic                      o_roi_last;
    logic                      o_frame_err;

    modport master (
        output o_roi_valid,
        output o_roi_data,
        output o_qubit_id,
        output o_roi_last,
        output o_frame_err,
        input  i_roi_ready
    );

    modport slave (
        input  o_roi_valid,
        input  o_roi_data,
        input  o_qubit_id,
        input  o_roi_last,
        input  o_frame_err,
        output i_roi_ready
    );

endinterface

// File: rtl/roi_lane_serializer.sv
// Captures one storage row across all lanes and serializes it onto the ROI beat
// stream, skipping lanes that lie beyond the last qubit of the frame.
module roi_lane_serializer #(
    parameter int ROI_BITS        = 72,
    parameter int NUM_QUBITS      = 100,
    parameter int NUM_LANES       = 4,
    parameter int BANK_ADDR_WIDTH = 5,
    parameter int QUBIT_ID_WIDTH  = 7,
    parameter int MAX_LANES       = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_load,
    input  logic [BANK_ADDR_WIDTH-1:0] i_row,
    input  logic [ROI_BITS-1:0]        i_lane_data [MAX_LANES],
    input  logic                       i_err_sticky,
    output logic                       o_row_done,
    output logic                       o_frame_done,
    roi_readout_sequencer_if.master    roi
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [QUBIT_ID_WIDTH-1:0] LAST_ID   = QUBIT_ID_WIDTH'(NUM_QUBITS - 1);
    localparam logic [LANE_W-1:0]         LAST_LANE = LANE_W'(NUM_LANES - 1);

    logic [ROI_BITS-1:0]       hold_r [NUM_LANES];
    logic [LANE_W-1:0]         lane_r;
    logic                      valid_r;
    logic [ROI_BITS-1:0]       data_r;
    logic [QUBIT_ID_WIDTH-1:0] id_r;
    logic                      last_r;

    logic                      xfer_s;
    logic                      lane_end_s;
    logic [LANE_W-1:0]         lane_nxt_s;
    logic [QUBIT_ID_WIDTH-1:0] id_nxt_s;
    logic [QUBIT_ID_WIDTH-1:0] row_base_s;

    // Handshake decode and next-beat arithmetic.
    always_comb begin
        xfer_s     = valid_r & roi.i_roi_ready;
        lane_end_s = (lane_r == LAST_LANE) || last_r;
        lane_nxt_s = lane_r + LANE_W'(1);
        id_nxt_s   = id_r + QUBIT_ID_WIDTH'(1);
        row_base_s = QUBIT_ID_WIDTH'(i_row) * QUBIT_ID_WIDTH'(NUM_LANES);
    end

    // Row holding register; contents are only consumed after a load.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                hold_r[l] <= i_lane_data[l];
            end
        end
    end

    // Beat registers: the presented word is preloaded so outputs stay flop-driven.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r <= 1'b0;
            lane_r  <= '0;
            data_r  <= '0;
            id_r    <= '0;
            last_r  <= 1'b0;
        end else if (i_load) begin
            valid_r <= 1'b1;
            lane_r  <= '0;
            data_r  <= i_lane_data[0];
            id_r    <= row_base_s;
            last_r  <= (row_base_s == LAST_ID);
        end else if (xfer_s) begin
            if (lane_end_s) begin
                valid_r <= 1'b0;
            end else begin
                lane_r <= lane_nxt_s;
                data_r <= hold_r[lane_nxt_s];
                id_r   <= id_nxt_s;
                last_r <= (id_nxt_s == LAST_ID);
            end
        end
    end

    assign o_row_done      = xfer_s & lane_end_s;
    assign o_frame_done    = xfer_s & last_r;
    assign roi.o_roi_valid = valid_r;
    assign roi.o_roi_data  = data_r;
    assign roi.o_qubit_id  = id_r;
    assign roi.o_roi_last  = last_r;
    assign roi.o_frame_err = i_err_sticky & last_r & valid_r;

endmodule

// File: rtl/roi_readout_sequencer.sv
// Frame readout sequencer: sweeps the ROI store row by row after a frame-ready
// pulse and streams one beat per qubit, tracking frame overruns.
module roi_readout_sequencer #(
    parameter int ROI_BITS        = roi_readout_sequencer_pkg::ROI_BITS,
    parameter int NUM_QUBITS      = roi_readout_sequencer_pkg::NUM_QUBITS,
    parameter int NUM_LANES       = roi_readout_sequencer_pkg::NUM_LANES,
    parameter int BANK_ADDR_WIDTH = roi_readout_sequencer_pkg::BANK_ADDR_WIDTH,
    parameter int QUBIT_ID_WIDTH  = roi_readout_sequencer_pkg::QUBIT_ID_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_frame_ready,
    output logic                       o_rd_en,
    output logic [BANK_ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [ROI_BITS-1:0]        i_rd_data_0,
    input  logic [ROI_BITS-1:0]        i_rd_data_1,
    input  logic [ROI_BITS-1:0]        i_rd_data_2,
    input  logic [ROI_BITS-1:0]        i_rd_data_3,
    roi_readout_sequencer_if.master    roi,
    output logic                       o_busy,
    output logic [7:0]                 o_overrun_cnt
);

    import roi_readout_sequencer_pkg::state_e;
    import roi_readout_sequencer_pkg::ST_IDLE;
    import roi_readout_sequencer_pkg::ST_ISSUE;
    import roi_readout_sequencer_pkg::ST_WAIT;
    import roi_readout_sequencer_pkg::ST_EMIT;
    import roi_readout_sequencer_pkg::sat_inc8;
    import roi_readout_sequencer_pkg::MAX_LANES;

    state_e                     state_r;
    state_e                     state_nxt_s;
    logic [BANK_ADDR_WIDTH-1:0] row_r;
    logic [BANK_ADDR_WIDTH-1:0] row_nxt_s;
    logic                       rd_en_r;
    logic [BANK_ADDR_WIDTH-1:0] rd_addr_r;
    logic                       busy_r;
    logic [7:0]                 ovr_cnt_r;
    logic                       err_sticky_r;

    logic                       load_s;
    logic                       overrun_s;
    logic                       row_done_s;
    logic                       frame_done_s;
    logic [ROI_BITS-1:0]        lane_data_s [MAX_LANES];

    assign lane_data_s[0] = i_rd_data_0;
    assign lane_data_s[1] = i_rd_data_1;
    assign lane_data_s[2] = i_rd_data_2;
    assign lane_data_s[3] = i_rd_data_3;

    // Sweep FSM next state; a frame-ready on the final transfer chains a new sweep.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        case (state_r)
            ST_IDLE: begin
                if (i_frame_ready) begin
                    state_nxt_s = ST_ISSUE;
                    row_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT:  state_nxt_s = ST_EMIT;
            ST_EMIT: begin
                if (frame_done_s) begin
                    state_nxt_s = i_frame_ready ? ST_ISSUE : ST_IDLE;
                    row_nxt_s   = '0;
                end else if (row_done_s) begin
                    state_nxt_s = ST_ISSUE;
                    row_nxt_s   = row_r + BANK_ADDR_WIDTH'(1);
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                row_nxt_s   = '0;
            end
        endcase
    end

    // Side conditions: lane capture and overrun detection.
    always_comb begin
        load_s    = (state_r == ST_WAIT);
        overrun_s = i_frame_ready & busy_r & ~frame_done_s;
    end

    // State, read port, busy and overrun bookkeeping registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            row_r        <= '0;
            rd_en_r      <= 1'b0;
            rd_addr_r    <= '0;
            busy_r       <= 1'b0;
            ovr_cnt_r    <= 8'd0;
            err_sticky_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            rd_en_r <= (state_nxt_s == ST_ISSUE);
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (state_nxt_s == ST_ISSUE) begin
                rd_addr_r <= row_nxt_s;
            end
            if (overrun_s) begin
                ovr_cnt_r    <= sat_inc8(ovr_cnt_r);
                err_sticky_r <= 1'b1;
            end else if (frame_done_s) begin
                err_sticky_r <= 1'b0;
            end
        end
    end

    roi_lane_serializer #(
        .ROI_BITS        (ROI_BITS),
        .NUM_QUBITS      (NUM_QUBITS),
        .NUM_LANES       (NUM_LANES),
        .BANK_ADDR_WIDTH (BANK_ADDR_WIDTH),
        .QUBIT_ID_WIDTH  (QUBIT_ID_WIDTH),
        .MAX_LANES       (MAX_LANES)
    ) u_serializer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (load_s),
        .i_row        (row_r),
        .i_lane_data  (lane_data_s),
        .i_err_sticky (err_sticky_r),
        .o_row_done   (row_done_s),
        .o_frame_done (frame_done_s),
        .roi          (roi)
    );

    assign o_rd_en       = rd_en_r;
    assign o_rd_addr     = rd_addr_r;
    assign o_busy        = busy_r;
    assign o_overrun_cnt = ovr_cnt_r;

endmodule

// File: tb/tb_roi_readout_sequencer.sv
// Directed bench for the ROI readout sequencer: start-of-frame vector table plus
// sequences for stalls, overrun, chained frames, mid-sweep reset and a partial row.
module tb_roi_readout_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fr;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [71:0] d0, d1, d2, d3;
    logic        busy;
    logic [7:0]  ovr;

    logic        fr_b;
    logic        rd_en_b;
    logic [4:0]  rd_addr_b;
    logic [71:0] e0, e1, e2, e3;
    logic        busy_b;
    logic [7:0]  ovr_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    roi_readout_sequencer_if #(.ROI_BITS(72), .QUBIT_ID_WIDTH(7)) rif ();
    roi_readout_sequencer_if #(.ROI_BITS(72), .QUBIT_ID_WIDTH(7)) rif_b ();

    roi_readout_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_frame_ready(fr), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .i_rd_data_0(d0), .i_rd_data_1(d1), .i_rd_data_2(d2), .i_rd_data_3(d3),
        .roi(rif), .o_busy(busy), .o_overrun_cnt(ovr)
    );

    roi_readout_sequencer #(.NUM_QUBITS(98)) dut98 (
        .i_clk(clk), .i_rst(rst), .i_frame_ready(fr_b), .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b),
        .i_rd_data_0(e0), .i_rd_data_1(e1), .i_rd_data_2(e2), .i_rd_data_3(e3),
        .roi(rif_b), .o_busy(busy_b), .o_overrun_cnt(ovr_b)
    );

    function automatic logic [71:0] mk(input int r, input int l);
        return {8'hA5, 48'h0, r[7:0], l[7:0]};
    endfunction

    // Storage model: row r lane l holds {r,l}, data one cycle after the read enable.
    always @(posedge clk) begin
        if (rd_en) begin
            d0 <= mk(int'(rd_addr), 0); d1 <= mk(int'(rd_addr), 1);
            d2 <= mk(int'(rd_addr), 2); d3 <= mk(int'(rd_addr), 3);
        end
        if (rd_en_b) begin
            e0 <= mk(int'(rd_addr_b), 0); e1 <= mk(int'(rd_addr_b), 1);
            e2 <= mk(int'(rd_addr_b), 2); e3 <= mk(int'(rd_addr_b), 3);
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Consume beats on dut, checking every presented cycle against the model.
    task automatic collect(input int start_id, input int pct, input int ovr_at, input bit exp_err,
                           input bit coincide, input int stop_at, output int beats);
        int  exp_id;
        int  cycles;
        bit  done;
        bit  r;
        exp_id = start_id; beats = 0; cycles = 0; done = 1'b0;
        while (!done && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            fr = 1'b0;
            if (rif.o_roi_valid) begin
                chk("beat_id", rif.o_qubit_id, exp_id);
                chk("beat_data", rif.o_roi_data, mk(exp_id / 4, exp_id % 4));
                chk("beat_last", rif.o_roi_last, exp_id == 99);
                chk("beat_err", rif.o_frame_err, (exp_id == 99) ? exp_err : 1'b0);
                if (stop_at >= 0 && exp_id == stop_at) begin
                    rif.i_roi_ready = 1'b0;
                    rst  = 1'b1;
                    done = 1'b1;
                end else begin
                    r = (pct >= 100) || ($urandom_range(99) < pct);
                    rif.i_roi_ready = r;
                    if (r) begin
                        if (beats == ovr_at) fr = 1'b1;
                        if (exp_id == 99) begin
                            done = 1'b1;
                            if (coincide) fr = 1'b1;
                        end
                        exp_id++;
                        beats++;
                    end
                end
            end else begin
                rif.i_roi_ready = 1'($urandom_range(1));
            end
        end
        if (!done) chk("collect_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit fr; bit rdy; bit rd_en; int addr; bit valid; int id; bit busy;
    } vec_t;

    vec_t tbl [11];
    int   beats;

    initial begin
        rst = 1'b1; fr = 1'b0; fr_b = 1'b0;
        rif.i_roi_ready = 1'b0; rif_b.i_roi_ready = 1'b1;

        tbl[0]  = '{1, 1, 1, 0, 0, 0, 1};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 1};
        tbl[2]  = '{0, 1, 0, 0, 1, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 1, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 1};
        tbl[5]  = '{0, 1, 0, 0, 1, 1, 1};
        tbl[6]  = '{0, 1, 0, 0, 1, 2, 1};
        tbl[7]  = '{0, 1, 0, 0, 1, 3, 1};
        tbl[8]  = '{0, 1, 1, 1, 0, 0, 1};
        tbl[9]  = '{0, 1, 0, 1, 0, 0, 1};
        tbl[10] = '{0, 1, 0, 1, 1, 4, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_rd_addr", rd_addr, 5'd0);
        chk("rst_valid", rif.o_roi_valid, 1'b0);
        chk("rst_last", rif.o_roi_last, 1'b0);
        chk("rst_err", rif.o_frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovr", ovr, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Frame start: latency, first row, a two-cycle stall and the second row issue.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            fr = tbl[i].fr;
            rif.i_roi_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rd_en", i), rd_en, tbl[i].rd_en);
            chk($sformatf("vec%0d_rd_addr", i), rd_addr, tbl[i].addr);
            chk($sformatf("vec%0d_valid", i), rif.o_roi_valid, tbl[i].valid);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            if (tbl[i].valid) begin
                chk($sformatf("vec%0d_id", i), rif.o_qubit_id, tbl[i].id);
                chk($sformatf("vec%0d_data", i), rif.o_roi_data, mk(tbl[i].id / 4, tbl[i].id % 4));
            end
        end
        collect(4, 100, -1, 1'b0, 1'b0, -1, beats);
        chk("frame1_beats", beats, 96);
        chk("frame1_idle_valid", rif.o_roi_valid, 1'b0);
        chk("frame1_idle_busy", busy, 1'b0);

        // Backpressure at 30 % ready duty.
        @(negedge clk); fr = 1'b1;
        collect(0, 30, -1, 1'b0, 1'b0, -1, beats);
        chk("stall_beats", beats, 100);
        chk("stall_ovr", ovr, 8'd0);

        // Overrun at beat 40, then a clean frame.
        @(negedge clk); fr = 1'b1;
        collect(0, 100, 40, 1'b1, 1'b0, -1, beats);
        chk("ovr_beats", beats, 100);
        chk("ovr_cnt", ovr, 8'd1);
        @(negedge clk); fr = 1'b1;
        collect(0, 100, -1, 1'b0, 1'b0, -1, beats);
        chk("clean_beats", beats, 100);
        chk("clean_ovr", ovr, 8'd1);

        // Frame-ready coincident with the final transfer chains a new sweep.
        @(negedge clk); fr = 1'b1;
        collect(0, 100, -1, 1'b0, 1'b1, -1, beats);
        chk("chain_rd_en", rd_en, 1'b1);
        chk("chain_rd_addr", rd_addr, 5'd0);
        chk("chain_busy", busy, 1'b1);
        chk("chain_ovr", ovr, 8'd1);
        collect(0, 100, -1, 1'b0, 1'b0, -1, beats);
        chk("chain2_beats", beats, 100);

        // Reset while beat 50 is presented.
        @(negedge clk); fr = 1'b1;
        collect(0, 100, -1, 1'b0, 1'b0, 50, beats);
        chk("mrst_beats", beats, 50);
        chk("mrst_valid", rif.o_roi_valid, 1'b0);
        chk("mrst_last", rif.o_roi_last, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ovr", ovr, 8'd0);
        @(negedge clk); rst = 1'b0; rif.i_roi_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mrst_quiet_valid", rif.o_roi_valid, 1'b0);
            chk("mrst_quiet_rd_en", rd_en, 1'b0);
        end
        fr = 1'b1;
        collect(0, 100, -1, 1'b0, 1'b0, -1, beats);
        chk("mrst_restart_beats", beats, 100);

        // Partial last row on the 98-qubit instance.
        begin
            int  exp_id;
            int  reads;
            int  max_addr;
            bit  done;
            exp_id = 0; reads = 0; max_addr = -1; done = 1'b0;
            @(negedge clk); fr_b = 1'b1;
            for (int c = 0; c < 1000 && !done; c++) begin
                @(negedge clk);
                fr_b = 1'b0;
                if (rd_en_b) begin
                    reads++;
                    if (int'(rd_addr_b) > max_addr) max_addr = int'(rd_addr_b);
                end
                if (rif_b.o_roi_valid) begin
                    chk("p98_id", rif_b.o_qubit_id, exp_id);
                    chk("p98_data", rif_b.o_roi_data, mk(exp_id / 4, exp_id % 4));
                    chk("p98_last", rif_b.o_roi_last, exp_id == 97);
                    if (exp_id == 97) done = 1'b1;
                    exp_id++;
                end
            end
            if (!done) chk("p98_timeout", 1'b0, 1'b1);
            @(posedge clk);
            #1;
            chk("p98_beats", exp_id, 98);
            chk("p98_reads", reads, 25);
            chk("p98_max_addr", max_addr, 24);
            chk("p98_idle_valid", rif_b.o_roi_valid, 1'b0);
            chk("p98_idle_busy", busy_b, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/roi_readout_sequencer.md
ROI_READOUT_SEQUENCER -- requirements
Module: roi_readout_sequencer

Interface
REQ-001 SHALL take parameter ROI_BITS, default 72: width of one qubit ROI word.
REQ-002 SHALL take parameter NUM_QUBITS, default 100: qubits per frame.
REQ-003 SHALL take parameter NUM_LANES, default 4: parallel read lanes from ROI storage.
REQ-004 SHALL take parameter BANK_ADDR_WIDTH, default 5: row address width.
REQ-005 SHALL take parameter QUBIT_ID_WIDTH, default 7: qubit index width.
REQ-006 SHALL have port i_clk, input, 1: single clock; all logic rises on it.
REQ-007 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port i_frame_ready, input, 1: one-cycle pulse; a completed frame is readable.
REQ-009 SHALL have port o_rd_en, output, 1: storage read enable.
REQ-010 SHALL have port o_rd_addr, output, BANK_ADDR_WIDTH: storage row address.
REQ-011 SHALL have port i_rd_data_0..3, input, ROI_BITS each: lane data, valid one cycle after o_rd_en.
REQ-012 SHALL have port o_roi_valid, output, 1: an output beat is presented.
REQ-013 SHALL have port i_roi_ready, input, 1: downstream accepts the beat.
REQ-014 SHALL have port o_roi_data, output, ROI_BITS: ROI word of one qubit.
REQ-015 SHALL have port o_qubit_id, output, QUBIT_ID_WIDTH: qubit index = row*NUM_LANES+lane.
REQ-016 SHALL have port o_roi_last, output, 1: marks the beat of qubit NUM_QUBITS-1.
REQ-017 SHALL have port o_frame_err, output, 1: qualifies the last beat; the frame was overrun.
REQ-018 SHALL have port o_busy, output, 1: a sweep is in progress.
REQ-019 SHALL have port o_overrun_cnt, output, 8: count of overruns, saturating at 255.

Function
REQ-020 SHALL implement FSM IDLE, ISSUE, WAIT, EMIT.
- IDLE: o_busy=0. i_frame_ready -> ISSUE, row=0.
REQ-021 ISSUE SHALL drive o_rd_en=1 with o_rd_addr=row for exactly one cycle, then go to WAIT.
REQ-022 WAIT SHALL capture all four lanes into a holding register at the cycle end, set lane=0, then go to EMIT.
REQ-023 EMIT SHALL present holding[lane] with o_roi_valid=1; the beat transfers only on o_roi_valid&&i_roi_ready.
REQ-024 While o_roi_valid=1 and i_roi_ready=0, o_roi_data, o_qubit_id and o_roi_last SHALL hold stable.
REQ-025 On a transfer, lane SHALL advance; after lane NUM_LANES-1, or after qubit NUM_QUBITS-1, the FSM SHALL advance row and go to ISSUE, or go to IDLE if the frame is finished.
REQ-026 Lanes with qubit_id >= NUM_QUBITS SHALL be skipped: no beat is emitted for them (partial last row).
- Row count = ceil(NUM_QUBITS/NUM_LANES); the default is 25 rows, 100 beats.
REQ-027 Latency SHALL be fixed: i_frame_ready sampled at cycle T -> o_rd_en at T+1 -> first o_roi_valid at T+3.
- Each subsequent row costs 2 cycles beyond its beats.
REQ-028 o_rd_en SHALL be 0 outside ISSUE; o_rd_addr SHALL hold its last value when o_rd_en=0.
REQ-029 i_frame_ready while o_busy=1 SHALL:
- increment o_overrun_cnt (saturating);
- set an internal sticky error flag;
- not restart or abort the sweep.
REQ-030 o_frame_err SHALL equal the sticky flag on the o_roi_last beat; the flag SHALL clear when that beat transfers.
REQ-031 i_frame_ready arriving in the same cycle as the final transfer SHALL start a new sweep (ISSUE next cycle) and SHALL NOT count as an overrun.
REQ-032 o_roi_valid SHALL not depend combinationally on i_roi_ready.

Reset
REQ-033 i_rst SHALL force, at the next edge:
- FSM to IDLE;
- o_rd_en=0, o_rd_addr=0;
- o_roi_valid=0, o_roi_last=0, o_frame_err=0;
- o_busy=0, o_overrun_cnt=0;
- sticky flag, row and lane to 0.
REQ-034 Reset mid-sweep SHALL discard the frame with no further beats; a later i_frame_ready starts cleanly from row 0.
REQ-035 The holding register SHALL not require reset.

Structure
REQ-036 ROI_BITS, NUM_QUBITS, NUM_LANES, BANK_ADDR_WIDTH, QUBIT_ID_WIDTH and the FSM state enum SHALL live in the shared qubit readout package.
REQ-037 A sub-module roi_lane_serializer SHALL hold the NUM_LANES-wide holding register and lane counter, and drive the valid/ready output.

Verification
REQ-038 Frame_ready pulse, i_roi_ready=1, storage model row r lane l = {r,l} -> exactly 100 beats, ids 0..99 in order.
- Data matches the model; o_roi_last only on id 99; first valid 3 cycles after the pulse.
REQ-039 Random i_roi_ready at 30% duty -> no lost or duplicated beats; outputs are stable during every stall.
REQ-040 Second frame_ready at beat 40 -> o_overrun_cnt=1; sweep completes with 100 beats; o_frame_err=1 on id 99 only.
- Next clean frame has o_frame_err=0.
REQ-041 NUM_QUBITS=98 -> 25 rows read; row 24 emits only ids 96 and 97; o_roi_last on id 97.
REQ-042 i_rst asserted at beat 50 -> o_roi_valid=0 at the next cycle; new frame_ready yields ids from 0; o_overrun_cnt=0.
REQ-043 Frame_ready coincident with the final transfer -> o_rd_en at the next cycle with o_rd_addr=0; o_overrun_cnt unchanged.
